// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared constants and types for the tone generator path. The note decoder
// uses the same package so that its jump/remainder widths match the phase
// accumulator's input widths.
//
// Contents:
//   JUMP_W, REM_W  - integer / fractional increment widths
//   FRAC_MOD       - modulus of the fractional accumulator (remainder units)
//   REM_MAX        - largest legal remainder, the saturation value
//   tone_state_t   - phase accumulator state encoding (IDLE / RUN / PEND)
//   sat_rem()      - clamps an out-of-range remainder to REM_MAX
// ---------------------------------------------------------------------------
package tone_pkg;

    localparam int JUMP_W = 6;
    localparam int REM_W  = 27;

    localparam logic [REM_W-1:0] FRAC_MOD = 27'd100000000;
    localparam logic [REM_W-1:0] REM_MAX  = FRAC_MOD - 27'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } tone_state_t;

    function automatic logic [REM_W-1:0] sat_rem(input logic [REM_W-1:0] r);
        return (r >= FRAC_MOD) ? REM_MAX : r;
    endfunction

endpackage

// File: rtl/tone_frac_step.sv
// ---------------------------------------------------------------------------
// tone_frac_step
// Purely combinational single-step update of the phase accumulator. All of
// the modulus arithmetic lives here.
//
// Parameters:
//   ADDR_W     - wavetable address width (must be >= JUMP_W)
// Ports:
//   frac       in   REM_W   current fractional accumulator
//   inc_r      in   REM_W   fractional increment (already < FRAC_MOD)
//   inc_j      in   JUMP_W  integer increment
//   addr       in   ADDR_W  current address
//   frac_next  out  REM_W   fractional accumulator after the step
//   addr_next  out  ADDR_W  address after the step (mod 2^ADDR_W)
//   ovf        out  1       the address step crossed 2^ADDR_W
// ---------------------------------------------------------------------------
module tone_frac_step
    import tone_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [REM_W-1:0]  frac,
    input  logic [REM_W-1:0]  inc_r,
    input  logic [JUMP_W-1:0] inc_j,
    input  logic [ADDR_W-1:0] addr,
    output logic [REM_W-1:0]  frac_next,
    output logic [ADDR_W-1:0] addr_next,
    output logic              ovf
);

    logic [REM_W:0]  sum;
    logic [REM_W:0]  mod_ext;
    logic [REM_W:0]  reduced;
    logic            carry;
    logic [ADDR_W:0] addr_sum;
    logic            unused_reduced_msb;

    always_comb begin
        mod_ext = {1'b0, FRAC_MOD};
        // One extra bit so frac + inc_r (each < FRAC_MOD) never overflows.
        sum     = {1'b0, frac} + {1'b0, inc_r};
        carry   = (sum >= mod_ext);
        reduced = carry ? (sum - mod_ext) : sum;
        frac_next = reduced[REM_W-1:0];

        addr_sum = {1'b0, addr}
                 + {{(ADDR_W + 1 - JUMP_W){1'b0}}, inc_j}
                 + {{ADDR_W{1'b0}}, carry};
        addr_next = addr_sum[ADDR_W-1:0];
        ovf       = addr_sum[ADDR_W];
    end

    // After reduction the result is always < FRAC_MOD, so the top bit is 0.
    assign unused_reduced_msb = reduced[REM_W];

endmodule

// File: rtl/tone_phase_acc.sv
// ---------------------------------------------------------------------------
// tone_phase_acc
// Fractional phase accumulator: turns a jump/remainder increment pair from
// the note table into a wavetable read address, advancing once per tick.
//
// Build option: TONE_GLITCHLESS_EN
//   defined   - a load while playing is held in shadow registers (PEND) and
//               takes over only after the first wrapping step, so the
//               waveform period in progress is completed with the old pitch.
//   undefined - a load while playing takes effect from the next tick; no
//               shadow registers or PEND state are built.
//
// Parameters:
//   ADDR_W      - wavetable address width, address wraps mod 2^ADDR_W
// Ports:
//   clk         in   1       system clock
//   rst         in   1       asynchronous active-high reset
//   tick        in   1       single-cycle sample strobe
//   note_on     in   1       gate level, high = play
//   load        in   1       single-cycle pulse capturing jump/remainder
//   jump        in   6       integer step per tick
//   remainder   in   27      fractional step per tick (units of 1/FRAC_MOD)
//   addr        out  ADDR_W  wavetable address
//   addr_valid  out  1       one-cycle pulse marking a new addr
//   wrap        out  1       one-cycle pulse with addr_valid on overflow
//   active      out  1       high in RUN and PEND
//   state_dbg   out  2       current FSM state (tone_state_t encoding)
//
// Strobes: tick and load are one-cycle pulses sampled on the rising clock
// edge; there is no back-pressure, so every sampled strobe is acted on in
// that cycle. addr_valid/wrap are one-cycle pulses with no ready.
// ---------------------------------------------------------------------------
module tone_phase_acc
    import tone_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              note_on,
    input  logic              load,
    input  logic [5:0]        jump,
    input  logic [26:0]       remainder,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              wrap,
    output logic              active,
    output logic [1:0]        state_dbg
);

    tone_state_t       state_q, state_d;
    logic              note_prev_q, note_prev_d;
    logic [JUMP_W-1:0] inc_j_q, inc_j_d;
    logic [REM_W-1:0]  inc_r_q, inc_r_d;
    logic [REM_W-1:0]  frac_q, frac_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic              wrap_q, wrap_d;
    logic              active_q, active_d;

`ifdef TONE_GLITCHLESS_EN
    logic [JUMP_W-1:0] sh_j_q, sh_j_d;
    logic [REM_W-1:0]  sh_r_q, sh_r_d;
    logic              sh_zero;
`endif

    logic              note_rise;
    logic              load_zero;
    logic [REM_W-1:0]  rem_sat;
    logic [REM_W-1:0]  step_frac;
    logic [ADDR_W-1:0] step_addr;
    logic              step_ovf;

    assign note_rise = note_on & ~note_prev_q;
    assign load_zero = load && (jump == '0) && (remainder == '0);
    assign rem_sat   = sat_rem(remainder);

`ifdef TONE_GLITCHLESS_EN
    assign sh_zero = (sh_j_q == '0) && (sh_r_q == '0);
`endif

    tone_frac_step #(
        .ADDR_W   (ADDR_W)
    ) u_step (
        .frac      (frac_q),
        .inc_r     (inc_r_q),
        .inc_j     (inc_j_q),
        .addr      (addr_q),
        .frac_next (step_frac),
        .addr_next (step_addr),
        .ovf       (step_ovf)
    );

    // ---------------- state / data registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            note_prev_q  <= 1'b0;
            inc_j_q      <= '0;
            inc_r_q      <= '0;
            frac_q       <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            active_q     <= 1'b0;
`ifdef TONE_GLITCHLESS_EN
            sh_j_q       <= '0;
            sh_r_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            note_prev_q  <= note_prev_d;
            inc_j_q      <= inc_j_d;
            inc_r_q      <= inc_r_d;
            frac_q       <= frac_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            wrap_q       <= wrap_d;
            active_q     <= active_d;
`ifdef TONE_GLITCHLESS_EN
            sh_j_q       <= sh_j_d;
            sh_r_q       <= sh_r_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A zero increment is the invalid-note code; it keeps us silent
                // even if the gate rises in the same cycle.
                if (note_rise && !load_zero) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!note_on)       state_d = ST_IDLE;
                else if (load_zero) state_d = ST_IDLE;
`ifdef TONE_GLITCHLESS_EN
                else if (load)      state_d = ST_PEND;
`endif
            end
`ifdef TONE_GLITCHLESS_EN
            ST_PEND: begin
                if (!note_on) begin
                    state_d = ST_IDLE;
                end else if (tick && step_ovf) begin
                    // Hand-over point: the pending value becomes active. A
                    // load in this same cycle becomes the next pending value.
                    if (sh_zero)   state_d = ST_IDLE;
                    else if (load) state_d = ST_PEND;
                    else           state_d = ST_RUN;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath / output next values ----------------
    always_comb begin
        note_prev_d  = note_on;
        inc_j_d      = inc_j_q;
        inc_r_d      = inc_r_q;
        frac_d       = frac_q;
        addr_d       = addr_q;
        addr_valid_d = 1'b0;
        wrap_d       = 1'b0;
`ifdef TONE_GLITCHLESS_EN
        sh_j_d       = sh_j_q;
        sh_r_d       = sh_r_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    inc_j_d = jump;
                    inc_r_d = rem_sat;
                end
                // The start wins over a coincident tick: phase restarts at 0.
                if (note_rise) begin
                    frac_d = '0;
                    addr_d = '0;
                end
            end
            ST_RUN: begin
                // A coincident load still lets this tick use the old step,
                // because step_* is computed from the registered increment.
                if (tick) begin
                    frac_d       = step_frac;
                    addr_d       = step_addr;
                    addr_valid_d = 1'b1;
                    wrap_d       = step_ovf;
                end
                if (load) begin
`ifdef TONE_GLITCHLESS_EN
                    sh_j_d  = jump;
                    sh_r_d  = rem_sat;
`else
                    inc_j_d = jump;
                    inc_r_d = rem_sat;
`endif
                end
            end
`ifdef TONE_GLITCHLESS_EN
            ST_PEND: begin
                if (tick) begin
                    frac_d       = step_frac;
                    addr_d       = step_addr;
                    addr_valid_d = 1'b1;
                    wrap_d       = step_ovf;
                    if (step_ovf) begin
                        inc_j_d = sh_j_q;
                        inc_r_d = sh_r_q;
                    end
                end
                if (load) begin
                    sh_j_d = jump;
                    sh_r_d = rem_sat;
                end
            end
`endif
            default: ;
        endcase

        // Any exit to IDLE silences the voice and drops pending work.
        if (state_q != ST_IDLE && state_d == ST_IDLE) begin
            frac_d       = '0;
            addr_d       = '0;
            addr_valid_d = 1'b0;
            wrap_d       = 1'b0;
`ifdef TONE_GLITCHLESS_EN
            sh_j_d       = '0;
            sh_r_d       = '0;
`endif
        end

        active_d = (state_d != ST_IDLE);
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign wrap       = wrap_q;
    assign active     = active_q;
    assign state_dbg  = state_q;

endmodule
